pong_match_ctrl: RTL and testbench

Match-level sequencer for the Pong design. It sits between the UART receiver, the ball/paddle controllers and the 7-segment drivers. It turns received keystrokes and ball-out events into serve / play / point / game-over sequencing and keeps both players' scores. It replaces ad-hoc byte compares at the top level with one registered state machine, and is the single source of the play-enable and game-reset strobes.

---
 rtl/pong_pkg.sv | 23 ++
 rtl/pong_serve_timer.sv | 30 +++
 rtl/pong_match_ctrl.sv | 149 ++++++++++++++
 tb/tb_pong_match_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared types and key codes for the Pong match sequencer.
// Macro PONG_MATCH_PAUSE_EN adds the PAUSED state.
package pong_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SERVE  = 3'd1,
    ST_PLAY   = 3'd2,
    ST_POINT  = 3'd3,
    ST_OVER   = 3'd4
`ifdef PONG_MATCH_PAUSE_EN
    ,
    ST_PAUSED = 3'd5
`endif
  } state_e;

  localparam logic [7:0] KEY_ENTER = 8'h0D;
  localparam logic [7:0] KEY_QUIT  = 8'h71;
  localparam logic [7:0] KEY_PAUSE = 8'h70;

  localparam int SERVE_CNT_W = 8;

endpackage

// File: rtl/pong_serve_timer.sv
// Loadable frame down-counter; o_Done flags the tick that empties it.
// Load wins over a coincident enable.
module pong_serve_timer #(
  parameter int WIDTH = 8
) (
  input  logic             i_Clk,
  input  logic             i_Reset,
  input  logic             i_Load,
  input  logic [WIDTH-1:0] i_Load_Val,
  input  logic             i_Enable,
  output logic             o_Done
);

  logic [WIDTH-1:0] count_q;

  // count down on enabled ticks, never below zero
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      count_q <= '0;
    end else if (i_Load) begin
      count_q <= i_Load_Val;
    end else if (i_Enable && count_q != '0) begin
      count_q <= count_q - WIDTH'(1);
    end
  end

  assign o_Done = i_Enable && !i_Load &&
                  (count_q == WIDTH'(1));

endmodule

// File: rtl/pong_match_ctrl.sv
// Match sequencer: serve/play/point/over FSM and score keeping.
// Macro PONG_MATCH_PAUSE_EN enables 'p' pause/resume in play.
module pong_match_ctrl
  import pong_pkg::*;
#(
  parameter int WIN_SCORE    = 5,
  parameter int SERVE_FRAMES = 60,
  parameter int SCORE_WIDTH  = 4
) (
  input  logic                   i_Clk,
  input  logic                   i_Reset,
  input  logic                   i_Rx_DV,
  input  logic [7:0]             i_Rx_Byte,
  input  logic                   i_Frame_Start,
  input  logic                   i_Ball_Out,
  input  logic                   i_Out_Side,
  output logic                   o_Start_Play,
  output logic                   o_Game_Reset,
  output logic [SCORE_WIDTH-1:0] o_Score_Left,
  output logic [SCORE_WIDTH-1:0] o_Score_Right,
  output logic                   o_Winner,
  output logic [2:0]             o_State
);

  localparam logic [SCORE_WIDTH-1:0] WIN =
    SCORE_WIDTH'(WIN_SCORE);

  state_e state_q, state_d;
  logic [SCORE_WIDTH-1:0] score_l_d, score_r_d;
  logic winner_d, gr_req, load, clr, serve_done;
  logic key_enter, key_quit;

  assign key_enter = i_Rx_DV && (i_Rx_Byte == KEY_ENTER);
  assign key_quit  = i_Rx_DV && (i_Rx_Byte == KEY_QUIT);

`ifdef PONG_MATCH_PAUSE_EN
  logic key_pause;
  assign key_pause = i_Rx_DV && (i_Rx_Byte == KEY_PAUSE);
`endif

  function automatic logic [SCORE_WIDTH-1:0] sat_inc(
    input logic [SCORE_WIDTH-1:0] s
  );
    return (s >= WIN) ? WIN : s + SCORE_WIDTH'(1);
  endfunction

  pong_serve_timer #(
    .WIDTH(SERVE_CNT_W)
  ) u_serve_timer (
    .i_Clk      (i_Clk),
    .i_Reset    (i_Reset),
    .i_Load     (load),
    .i_Load_Val (SERVE_CNT_W'(SERVE_FRAMES)),
    .i_Enable   (i_Frame_Start && state_q == ST_SERVE),
    .o_Done     (serve_done)
  );

  // next state, score updates and strobe requests
  always_comb begin
    state_d   = state_q;
    score_l_d = o_Score_Left;
    score_r_d = o_Score_Right;
    winner_d  = o_Winner;
    gr_req    = 1'b0;
    load      = 1'b0;
    clr       = 1'b0;
    if (key_quit) begin
      state_d = ST_IDLE;
      clr     = 1'b1;
      gr_req  = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (key_enter) begin
            state_d = ST_SERVE;
            clr     = 1'b1;
            load    = 1'b1;
          end
        end
        ST_SERVE: begin
          if (serve_done) state_d = ST_PLAY;
        end
        ST_PLAY: begin
          if (i_Ball_Out) begin
            state_d = ST_POINT;
            if (i_Out_Side) score_l_d = sat_inc(o_Score_Left);
            else            score_r_d = sat_inc(o_Score_Right);
          end
`ifdef PONG_MATCH_PAUSE_EN
          else if (key_pause) begin
            state_d = ST_PAUSED;
          end
`endif
        end
`ifdef PONG_MATCH_PAUSE_EN
        ST_PAUSED: begin
          if (key_pause) state_d = ST_PLAY;
        end
`endif
        ST_POINT: begin
          gr_req = 1'b1;
          if (o_Score_Left == WIN || o_Score_Right == WIN) begin
            state_d  = ST_OVER;
            winner_d = (o_Score_Right == WIN);
          end else begin
            state_d = ST_SERVE;
            load    = 1'b1;
          end
        end
        ST_OVER: begin
          if (key_enter) begin
            state_d = ST_SERVE;
            clr     = 1'b1;
            load    = 1'b1;
            gr_req  = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    if (clr) begin
      score_l_d = '0;
      score_r_d = '0;
      winner_d  = 1'b0;
    end
  end

  // registered state and outputs
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q       <= ST_IDLE;
      o_Score_Left  <= '0;
      o_Score_Right <= '0;
      o_Winner      <= 1'b0;
      o_Start_Play  <= 1'b0;
      o_Game_Reset  <= 1'b0;
    end else begin
      state_q       <= state_d;
      o_Score_Left  <= score_l_d;
      o_Score_Right <= score_r_d;
      o_Winner      <= winner_d;
      o_Start_Play  <= (state_d == ST_PLAY);
      o_Game_Reset  <= gr_req && !o_Game_Reset;
    end
  end

  assign o_State = state_q;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Bench for pong_match_ctrl: vector table, pause sequence,
// then random traffic against a behavioural match model.
module tb_pong_match_ctrl;

  localparam int WIN = 2;
  localparam int SF  = 3;
  localparam logic [7:0] E = 8'h0D;
  localparam logic [7:0] Q = 8'h71;
  localparam logic [7:0] P = 8'h70;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       dv = 1'b0;
  logic [7:0] rb = 8'h00;
  logic       fs = 1'b0;
  logic       ball = 1'b0;
  logic       side = 1'b0;
  logic       sp, gr, win;
  logic [3:0] sl, sr;
  logic [2:0] st;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pong_match_ctrl #(
    .WIN_SCORE    (WIN),
    .SERVE_FRAMES (SF),
    .SCORE_WIDTH  (4)
  ) dut (
    .i_Clk         (clk),
    .i_Reset       (rst),
    .i_Rx_DV       (dv),
    .i_Rx_Byte     (rb),
    .i_Frame_Start (fs),
    .i_Ball_Out    (ball),
    .i_Out_Side    (side),
    .o_Start_Play  (sp),
    .o_Game_Reset  (gr),
    .o_Score_Left  (sl),
    .o_Score_Right (sr),
    .o_Winner      (win),
    .o_State       (st)
  );

  typedef struct {
    bit       rst, dv;
    bit [7:0] b;
    bit       fs, ball, side;
    int       st, sp, gr, l, r, w;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(
    bit r_, bit d_, bit [7:0] b_, bit f_, bit ba_, bit si_,
    int st_, int sp_, int gr_, int l_, int r2_, int w_);
    vec_t v;
    v.rst = r_; v.dv = d_; v.b = b_; v.fs = f_;
    v.ball = ba_; v.side = si_;
    v.st = st_; v.sp = sp_; v.gr = gr_;
    v.l = l_; v.r = r2_; v.w = w_;
    return v;
  endfunction

  task automatic chk(string n, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               n, act, exp, $time);
    end
  endtask

  task automatic cyc(bit r_, bit d_, bit [7:0] b_,
                     bit f_, bit ba_, bit si_);
    rst = r_; dv = d_; rb = b_;
    fs = f_; ball = ba_; side = si_;
    @(posedge clk);
    #1;
    rst = 0; dv = 0; rb = 0; fs = 0; ball = 0; side = 0;
  endtask

  task automatic chk_all(string tag, int e_st, int e_sp,
                         int e_gr, int e_l, int e_r, int e_w);
    chk({tag, ".state"}, int'(st), e_st);
    chk({tag, ".start_play"}, int'(sp), e_sp);
    chk({tag, ".game_reset"}, int'(gr), e_gr);
    chk({tag, ".score_l"}, int'(sl), e_l);
    chk({tag, ".score_r"}, int'(sr), e_r);
    chk({tag, ".winner"}, int'(win), e_w);
  endtask

  // behavioural match model: remaining serve frames and scores
  int m_st, m_rem;
  int m_sc[2];
  bit m_w, m_sp, m_gr;

  task automatic model(bit r_, bit d_, bit [7:0] b_,
                       bit f_, bit ba_, bit si_);
    int ns;
    bit ngr, clr, enter, quit, pause;
    ns = m_st; ngr = 0; clr = 0;
    enter = d_ && b_ == E;
    quit  = d_ && b_ == Q;
    pause = d_ && b_ == P;
    if (r_) begin
      m_st = 0; m_rem = 0; m_sc[0] = 0; m_sc[1] = 0;
      m_w = 0; m_sp = 0; m_gr = 0;
      return;
    end
    if (quit) begin
      ns = 0; clr = 1; ngr = 1;
    end else begin
      case (m_st)
        0: if (enter) begin ns = 1; clr = 1; m_rem = SF; end
        1: if (f_) begin
             m_rem = m_rem - 1;
             if (m_rem == 0) ns = 2;
           end
        2: begin
          if (ba_) begin
            int idx;
            idx = si_ ? 0 : 1;
            m_sc[idx] = (m_sc[idx] + 1 > WIN) ? WIN : m_sc[idx] + 1;
            ns = 3;
          end
`ifdef PONG_MATCH_PAUSE_EN
          else if (pause) ns = 5;
`endif
        end
        5: if (pause) ns = 2;
        3: begin
          ngr = 1;
          if (m_sc[0] == WIN || m_sc[1] == WIN) begin
            ns = 4; m_w = (m_sc[1] == WIN);
          end else begin
            ns = 1; m_rem = SF;
          end
        end
        4: if (enter) begin
             ns = 1; clr = 1; ngr = 1; m_rem = SF;
           end
        default: ns = 0;
      endcase
    end
    if (clr) begin m_sc[0] = 0; m_sc[1] = 0; m_w = 0; end
    m_gr = ngr && !m_gr;
    m_sp = (ns == 2);
    m_st = ns;
  endtask

  initial begin
    tv.push_back(mk(1,0,0,0,0,0, 0,0,0,0,0,0));
    tv.push_back(mk(0,1,E,0,0,0, 1,0,0,0,0,0));
    tv.push_back(mk(0,0,0,1,0,0, 1,0,0,0,0,0));
    tv.push_back(mk(0,0,0,0,0,0, 1,0,0,0,0,0));
    tv.push_back(mk(0,0,0,1,0,0, 1,0,0,0,0,0));
    tv.push_back(mk(0,0,0,1,0,0, 2,1,0,0,0,0));
    tv.push_back(mk(0,0,0,0,1,1, 3,0,0,1,0,0));
    tv.push_back(mk(0,0,0,0,0,0, 1,0,1,1,0,0));
    tv.push_back(mk(0,0,0,0,0,0, 1,0,0,1,0,0));
    tv.push_back(mk(0,0,0,1,0,0, 1,0,0,1,0,0));
    tv.push_back(mk(0,0,0,1,0,0, 1,0,0,1,0,0));
    tv.push_back(mk(0,0,0,1,0,0, 2,1,0,1,0,0));
    tv.push_back(mk(0,0,0,0,1,0, 3,0,0,1,1,0));
    tv.push_back(mk(0,0,0,0,0,0, 1,0,1,1,1,0));
    tv.push_back(mk(0,0,0,1,0,0, 1,0,0,1,1,0));
    tv.push_back(mk(0,0,0,1,0,0, 1,0,0,1,1,0));
    tv.push_back(mk(0,0,0,1,0,0, 2,1,0,1,1,0));
    tv.push_back(mk(0,0,0,0,1,0, 3,0,0,1,2,0));
    tv.push_back(mk(0,0,0,0,0,0, 4,0,1,1,2,1));
    tv.push_back(mk(0,0,0,0,1,0, 4,0,0,1,2,1));
    tv.push_back(mk(0,1,E,0,0,0, 1,0,1,0,0,0));
    tv.push_back(mk(0,1,Q,1,0,0, 0,0,0,0,0,0));
    tv.push_back(mk(0,1,E,0,0,0, 1,0,0,0,0,0));
    tv.push_back(mk(0,0,0,1,0,0, 1,0,0,0,0,0));
    tv.push_back(mk(0,0,0,1,0,0, 1,0,0,0,0,0));
    tv.push_back(mk(0,0,0,1,0,0, 2,1,0,0,0,0));
    tv.push_back(mk(0,1,Q,0,1,1, 0,0,1,0,0,0));
    tv.push_back(mk(0,0,0,0,0,0, 0,0,0,0,0,0));
    tv.push_back(mk(0,0,E,0,0,0, 0,0,0,0,0,0));
    tv.push_back(mk(0,1,E,0,0,0, 1,0,0,0,0,0));
    tv.push_back(mk(0,0,0,1,0,0, 1,0,0,0,0,0));
    tv.push_back(mk(1,1,Q,0,0,0, 0,0,0,0,0,0));
    tv.push_back(mk(0,1,P,0,0,0, 0,0,0,0,0,0));
    tv.push_back(mk(0,1,E,1,0,0, 1,0,0,0,0,0));
    tv.push_back(mk(0,0,0,1,0,0, 1,0,0,0,0,0));
    tv.push_back(mk(0,0,0,1,0,0, 1,0,0,0,0,0));
    tv.push_back(mk(0,0,0,1,0,0, 2,1,0,0,0,0));

    #2;
    foreach (tv[i]) begin
      cyc(tv[i].rst, tv[i].dv, tv[i].b,
          tv[i].fs, tv[i].ball, tv[i].side);
      chk_all($sformatf("vec%0d", i), tv[i].st, tv[i].sp,
              tv[i].gr, tv[i].l, tv[i].r, tv[i].w);
    end

    // pause handling from PLAY
`ifdef PONG_MATCH_PAUSE_EN
    cyc(0,1,P,0,0,0);
    chk_all("pause_on", 5,0,0,0,0,0);
    cyc(0,0,0,0,1,1);
    chk_all("pause_ball", 5,0,0,0,0,0);
    cyc(0,1,P,0,0,0);
    chk_all("pause_off", 2,1,0,0,0,0);
    cyc(0,0,0,0,1,1);
    chk_all("resume_ball", 3,0,0,1,0,0);
`else
    cyc(0,1,P,0,0,0);
    chk_all("p_ignored", 2,1,0,0,0,0);
    cyc(0,1,P,1,0,0);
    chk_all("p_ignored2", 2,1,0,0,0,0);
    cyc(0,0,0,0,1,1);
    chk_all("play_ball", 3,0,0,1,0,0);
`endif

    // randomized traffic against the model
    cyc(1,0,0,0,0,0);
    model(1,0,0,0,0,0);
    chk_all("rand_rst", m_st, m_sp, m_gr, m_sc[0], m_sc[1], m_w);
    for (int n = 0; n < 4000; n++) begin
      bit r_, d_, f_, ba_, si_;
      bit [7:0] b_;
      int k;
      r_  = ($urandom_range(299) == 0);
      d_  = ($urandom_range(11) == 0);
      k   = $urandom_range(9);
      b_  = (k < 5) ? E : (k == 5) ? Q : (k < 8) ? P :
            8'($urandom);
      f_  = ($urandom_range(3) == 0);
      ba_ = ($urandom_range(5) == 0);
      si_ = 1'($urandom);
      model(r_, d_, b_, f_, ba_, si_);
      cyc(r_, d_, b_, f_, ba_, si_);
      chk_all("rand", m_st, m_sp, m_gr, m_sc[0], m_sc[1], m_w);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
